icache_refill_ctrl: RTL and testbench
=====================================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LINE_WORDS, 4, 32-bit words per cache line; fixed at 4 in this revision.
- INDEX_BITS, 6, cache set index width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch stage is presenting fetch_addr this cycle.
- fetch_addr  in  32  current PC.
- hit  in  1  cache lookup result for fetch_addr.
- pc_src  in  1  branch redirect request.
- branch_target  in  32  redirect PC.
- stall  out  1  freeze PC and IF/ID register.
- redirect_valid  out  1  one-cycle pulse; fetch loads redirect_pc.
- redirect_pc  out  32  deferred branch target.
- mem_req  out  1  line read request.
- mem_addr  out  32  line-aligned address, {line_addr, 4'b0}.
- mem_ack  in  1  request accepted.
- mem_rvalid  in  1  one data word valid.
- mem_rdata  in  32  returned word; words arrive in order 0..3.
- refill_we  out  1  data-array write strobe.
- refill_index  out  INDEX_BITS  set being filled.
- refill_word  out  2  word offset being written.
- refill_data  out  32  equals mem_rdata.
- tag_we  out  1  tag/valid write strobe.
- refill_tag  out  32-INDEX_BITS-4  tag written on tag_we.

Function
REQ-003 FSM states SHALL be IDLE, REQ, FILL and DONE.
REQ-004 IDLE SHALL go to REQ on fetch_valid && !hit && !pc_src, latching line_addr = fetch_addr[31:4] and clearing the word counter.
REQ-005 In IDLE with pc_src=1, a simultaneous miss SHALL be ignored as wrong-path, and no refill SHALL start.
REQ-006 stall SHALL equal (state != IDLE) || (fetch_valid && !hit && !pc_src); it is combinational, so the miss cycle itself stalls.
REQ-007 REQ SHALL hold mem_req=1 with a stable mem_addr until mem_ack, then go to FILL; mem_req SHALL be 0 in all other states.
REQ-008 FILL SHALL assert refill_we in the same cycle as each mem_rvalid, with refill_word equal to the counter, and then increment the counter.
REQ-009 mem_rvalid SHALL be ignored in every state except FILL.
REQ-010 The counter SHALL be 2 bits and wrap to 0.
REQ-011 FILL SHALL go to DONE on the beat where mem_rvalid is high and the counter is 3.
REQ-012 DONE SHALL last exactly one cycle with tag_we=1, then go to IDLE.
REQ-013 refill_index SHALL be line_addr[INDEX_BITS-1:0] and refill_tag SHALL be line_addr[27:INDEX_BITS].
REQ-014 pc_src in REQ, FILL or DONE SHALL NOT abort the refill; it SHALL latch branch_target into pending_pc and set pending.
REQ-015 If several redirects arrive during one refill, the latest SHALL win.
REQ-016 In the cycle after DONE (state IDLE), a set pending flag SHALL produce redirect_valid=1 with redirect_pc=pending_pc, then clear pending.
REQ-017 While redirect_valid=1, a miss SHALL NOT start a refill.
REQ-018 Minimum miss penalty with zero-wait memory SHALL be 7 stall cycles: miss, REQ, 4 FILL, DONE.

Reset
REQ-019 rst SHALL force IDLE, counter=0, pending=0 and line_addr=0 at the next clock edge, overriding all other inputs.
REQ-020 After reset, all outputs SHALL be 0 except stall, which follows its REQ-006 expression.
REQ-021 Reset mid-refill SHALL abandon the line with no tag_we, so the set stays invalid; memory beats arriving afterwards SHALL be dropped.

Structure
REQ-022 The shared package SHALL hold the state enum, LINE_WORDS, INDEX_BITS, OFFSET_BITS=4 and TAG_BITS.
REQ-023 There SHALL be no sub-modules; the FSM, counter and redirect latch live in one module that sits between fetch and the instruction memory.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Hit at 0x00000040 -> stall=0, mem_req never asserted.
- Miss at 0x00001234, mem_ack on the first cycle, 4 consecutive rvalids carrying 0xA0..0xA3 -> mem_addr=0x00001230, refill_index=0x23, refill_word 0..3 matching the data, tag_we once with refill_tag=0x0004, stall high exactly 7 cycles.
- Miss with mem_ack delayed 3 cycles and rvalid gaps -> mem_req held and mem_addr stable; exactly 4 refill_we pulses.
- pc_src in FILL with target 0x00000100, then a second pc_src with 0x00000200 -> refill completes; one redirect_valid pulse with redirect_pc=0x00000200 in the cycle after DONE.
- Miss and pc_src in the same IDLE cycle -> no mem_req, stall=0.
- rst asserted on the second FILL beat -> IDLE next cycle, no tag_we, the remaining rvalids produce no refill_we, and the next miss to the same line refetches it.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl_pkg
// Description : Shared geometry constants and FSM state type for the
//               instruction-cache refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_refill_ctrl_pkg;

  localparam int LINE_WORDS  = 4;
  localparam int INDEX_BITS  = 6;
  localparam int OFFSET_BITS = 4;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : icache_refill_ctrl_pkg
`default_nettype wire

// File: rtl/icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl_if
// Description : Fetch / memory / cache-array bundle around the refill
//               controller. The master modport is the controller itself,
//               the slave modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_refill_ctrl_if;
  import icache_refill_ctrl_pkg::*;

  // fetch side
  logic                  fetch_valid;
  logic [31:0]           fetch_addr;
  logic                  hit;
  logic                  pc_src;
  logic [31:0]           branch_target;
  logic                  stall;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  // memory side
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_ack;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  // cache array side
  logic                  refill_we;
  logic [INDEX_BITS-1:0] refill_index;
  logic [1:0]            refill_word;
  logic [31:0]           refill_data;
  logic                  tag_we;
  logic [TAG_BITS-1:0]   refill_tag;

  modport master (
    input  fetch_valid, fetch_addr, hit, pc_src, branch_target,
    input  mem_ack, mem_rvalid, mem_rdata,
    output stall, redirect_valid, redirect_pc,
    output mem_req, mem_addr,
    output refill_we, refill_index, refill_word, refill_data,
    output tag_we, refill_tag
  );

  modport slave (
    output fetch_valid, fetch_addr, hit, pc_src, branch_target,
    output mem_ack, mem_rvalid, mem_rdata,
    input  stall, redirect_valid, redirect_pc,
    input  mem_req, mem_addr,
    input  refill_we, refill_index, refill_word, refill_data,
    input  tag_we, refill_tag
  );

endinterface : icache_refill_ctrl_if
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : Blocking I-cache miss handler. Requests a 4-word line,
//               streams the beats into the data array, writes the tag, and
//               defers any branch redirect seen during the refill until the
//               line is installed.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 6
) (
  input  wire                         clk,
  input  wire                         rst,
  icache_refill_ctrl_if.master        bus
);
  import icache_refill_ctrl_pkg::*;

  localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [27:0] line_addr_q;
  logic        pending_q;
  logic [31:0] pending_pc_q;

  logic        w_miss;
  logic        w_unused_offset;

  // A miss only counts when the fetch is on the correct path.
  assign w_miss          = bus.fetch_valid && !bus.hit && !bus.pc_src;
  assign w_unused_offset = ^bus.fetch_addr[3:0];

  // FSM, beat counter, line address and deferred-redirect latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      line_addr_q  <= 28'd0;
      pending_q    <= 1'b0;
      pending_pc_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The redirect cycle owns the fetch slot; a miss seen now is on
          // the path being abandoned, so it must not start a refill.
          if (pending_q) begin
            pending_q <= 1'b0;
          end else if (w_miss) begin
            state_q     <= ST_REQ;
            line_addr_q <= bus.fetch_addr[31:4];
            cnt_q       <= 2'd0;
          end
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (bus.mem_rvalid) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == LAST_WORD) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Redirects during a refill are remembered, latest target wins.
      if ((state_q != ST_IDLE) && bus.pc_src) begin
        pending_q    <= 1'b1;
        pending_pc_q <= bus.branch_target;
      end
    end
  end

  // Outputs: decoded from registered state except the same-cycle miss stall
  // and the data-array strobe, which tracks the memory beat directly.
  assign bus.stall          = (state_q != ST_IDLE) || w_miss;
  assign bus.redirect_valid = (state_q == ST_IDLE) && pending_q;
  assign bus.redirect_pc    = pending_pc_q;
  assign bus.mem_req        = (state_q == ST_REQ);
  assign bus.mem_addr       = {line_addr_q, 4'b0000};
  assign bus.refill_we      = (state_q == ST_FILL) && bus.mem_rvalid;
  assign bus.refill_index   = line_addr_q[INDEX_BITS-1:0];
  assign bus.refill_word    = cnt_q;
  assign bus.refill_data    = bus.mem_rdata;
  assign bus.tag_we         = (state_q == ST_DONE);
  assign bus.refill_tag     = line_addr_q[27:INDEX_BITS];

endmodule : icache_refill_ctrl
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_ctrl
// Description : Directed self-checking bench for icache_refill_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

  logic clk;
  logic rst;

  icache_refill_ctrl_if bus ();

  icache_refill_ctrl #(
    .LINE_WORDS (4),
    .INDEX_BITS (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int test_cnt = 0;
  int fail_cnt = 0;

  // per-scenario event counters, sampled mid-cycle
  int stall_cnt, req_cnt, we_cnt, tag_cnt, redir_cnt;

  always @(negedge clk) begin
    if (bus.stall)          stall_cnt++;
    if (bus.mem_req)        req_cnt++;
    if (bus.refill_we)      we_cnt++;
    if (bus.tag_we)         tag_cnt++;
    if (bus.redirect_valid) redir_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall_cnt = 0; req_cnt = 0; we_cnt = 0; tag_cnt = 0; redir_cnt = 0;
  endtask

  task automatic idle_inputs();
    bus.fetch_valid = 1'b0; bus.fetch_addr = 32'd0; bus.hit = 1'b0;
    bus.pc_src = 1'b0; bus.branch_target = 32'd0;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
  endtask

  // Zero-wait refill of one line; data words are base+0..base+3.
  task automatic quick_refill(input logic [31:0] addr, input logic [31:0] base);
    bus.fetch_valid = 1'b1; bus.fetch_addr = addr; bus.hit = 1'b0;
    tick();
    bus.fetch_valid = 1'b0; bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = base + 32'(i);
      tick();
    end
    bus.mem_rvalid = 1'b0;
    tick();  // DONE
  endtask

  bit pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int w;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;

    // ---- reset state ----
    check("rst_stall",    32'(bus.stall),          32'd0);
    check("rst_mem_req",  32'(bus.mem_req),        32'd0);
    check("rst_redir",    32'(bus.redirect_valid), 32'd0);
    check("rst_redir_pc", bus.redirect_pc,         32'd0);
    check("rst_mem_addr", bus.mem_addr,            32'd0);
    check("rst_we",       32'(bus.refill_we),      32'd0);
    check("rst_tag_we",   32'(bus.tag_we),         32'd0);
    check("rst_index",    32'(bus.refill_index),   32'd0);
    check("rst_tag",      32'(bus.refill_tag),     32'd0);
    tick();

    // ---- hit: no stall, no memory request ----
    clr();
    bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h0000_0040; bus.hit = 1'b1;
    #1;
    check("hit_stall", 32'(bus.stall), 32'd0);
    tick(); tick(); tick();
    idle_inputs();
    check("hit_req_cnt",   32'(req_cnt),   32'd0);
    check("hit_stall_cnt", 32'(stall_cnt), 32'd0);

    // ---- zero-wait miss at 0x1234 ----
    clr();
    bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h0000_1234; bus.hit = 1'b0;
    #1;
    check("m_miss_stall", 32'(bus.stall),   32'd1);
    check("m_miss_req",   32'(bus.mem_req), 32'd0);
    tick();
    bus.fetch_valid = 1'b0; bus.mem_ack = 1'b1;
    #1;
    check("m_req",      32'(bus.mem_req),      32'd1);
    check("m_mem_addr", bus.mem_addr,          32'h0000_1230);
    check("m_index",    32'(bus.refill_index), 32'h23);
    tick();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA0 + 32'(i);
      #1;
      check("m_we",   32'(bus.refill_we),   32'd1);
      check("m_word", 32'(bus.refill_word), 32'(i));
      check("m_data", bus.refill_data,      32'hA0 + 32'(i));
      tick();
    end
    bus.mem_rvalid = 1'b0;
    #1;
    check("m_tag_we", 32'(bus.tag_we),     32'd1);
    check("m_tag",    32'(bus.refill_tag), 32'h0004);
    tick();
    check("m_after_stall", 32'(bus.stall), 32'd0);
    tick();
    check("m_stall_cnt", 32'(stall_cnt), 32'd7);
    check("m_we_cnt",    32'(we_cnt),    32'd4);
    check("m_tag_cnt",   32'(tag_cnt),   32'd1);

    // ---- miss with delayed ack, rvalid in REQ, gapped beats ----
    clr();
    bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h0000_2008; bus.hit = 1'b0;
    tick();
    bus.fetch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mem_rvalid = (i == 0);  // stray beat before the grant
      #1;
      check("d_req_hold", 32'(bus.mem_req), 32'd1);
      check("d_addr",     bus.mem_addr,     32'h0000_2000);
      check("d_no_we",    32'(bus.refill_we), 32'd0);
      tick();
    end
    bus.mem_rvalid = 1'b0; bus.mem_ack = 1'b1;
    #1;
    check("d_addr_ack", bus.mem_addr, 32'h0000_2000);
    tick();
    bus.mem_ack = 1'b0;
    w = 0;
    for (int i = 0; i < 7; i++) begin
      bus.mem_rvalid = pat[i]; bus.mem_rdata = 32'hB0 + 32'(w);
      #1;
      if (pat[i]) begin
        check("d_word", 32'(bus.refill_word), 32'(w));
        w++;
      end
      tick();
    end
    bus.mem_rvalid = 1'b0;
    tick(); tick();
    check("d_we_cnt",    32'(we_cnt),    32'd4);
    check("d_tag_cnt",   32'(tag_cnt),   32'd1);
    check("d_req_cnt",   32'(req_cnt),   32'd4);
    check("d_stall_cnt", 32'(stall_cnt), 32'd13);

    // ---- two redirects during FILL, latest wins ----
    clr();
    bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h0000_3000; bus.hit = 1'b0;
    tick();
    bus.fetch_valid = 1'b0; bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hC0 + 32'(i);
      bus.pc_src = (i == 0) || (i == 2);
      bus.branch_target = (i == 0) ? 32'h0000_0100 : 32'h0000_0200;
      tick();
    end
    bus.mem_rvalid = 1'b0; bus.pc_src = 1'b0;
    #1;
    check("r_tag_we", 32'(bus.tag_we),         32'd1);
    check("r_no_redir_done", 32'(bus.redirect_valid), 32'd0);
    tick();
    // redirect cycle: a miss presented now must not start a refill
    bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h0000_5000; bus.hit = 1'b0;
    #1;
    check("r_redir_valid", 32'(bus.redirect_valid), 32'd1);
    check("r_redir_pc",    bus.redirect_pc,         32'h0000_0200);
    tick();
    bus.fetch_valid = 1'b0;
    #1;
    check("r_redir_clear", 32'(bus.redirect_valid), 32'd0);
    check("r_no_req",      32'(bus.mem_req),        32'd0);
    tick();
    check("r_redir_cnt", 32'(redir_cnt), 32'd1);
    check("r_we_cnt",    32'(we_cnt),    32'd4);

    // ---- miss together with pc_src in IDLE: wrong path ----
    clr();
    bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h0000_6000; bus.hit = 1'b0;
    bus.pc_src = 1'b1; bus.branch_target = 32'h0000_0400;
    #1;
    check("w_stall", 32'(bus.stall), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("w_no_req",   32'(bus.mem_req),        32'd0);
    check("w_no_redir", 32'(bus.redirect_valid), 32'd0);
    tick();
    check("w_req_cnt", 32'(req_cnt), 32'd0);

    // ---- reset on the second FILL beat ----
    clr();
    bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h0000_4560; bus.hit = 1'b0;
    tick();
    bus.fetch_valid = 1'b0; bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hD0;
    tick();
    bus.mem_rdata = 32'hD1; rst = 1'b1;
    tick();
    rst = 1'b0; bus.mem_rdata = 32'hD2;
    #1;
    check("x_stall", 32'(bus.stall),     32'd0);
    check("x_no_we", 32'(bus.refill_we), 32'd0);
    check("x_addr0", bus.mem_addr,       32'd0);
    we_cnt = 0;
    tick();
    bus.mem_rdata = 32'hD3;
    tick();
    bus.mem_rvalid = 1'b0;
    check("x_late_we_cnt", 32'(we_cnt),  32'd0);
    check("x_tag_cnt",     32'(tag_cnt), 32'd0);
    bus.fetch_valid = 1'b1; bus.fetch_addr = 32'h0000_4560; bus.hit = 1'b0;
    tick();
    bus.fetch_valid = 1'b0;
    #1;
    check("x_refetch_req",  32'(bus.mem_req), 32'd1);
    check("x_refetch_addr", bus.mem_addr,     32'h0000_4560);
    tick();
    clr();
    quick_refill(32'h0000_7010, 32'hE0);
    tick();
    check("x_refill_tag_cnt", 32'(tag_cnt), 32'd1);
    check("x_refill_we_cnt",  32'(we_cnt),  32'd4);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_icache_refill_ctrl
`default_nettype wire
